aes_subshift: RTL and testbench

- Sequential SubBytes + ShiftRows stage of the AES encryption round datapath.
- Sits directly upstream of the MixColumns combinational stage. Its state_out/finish drive that stage's data input and start input.
- Processes the 128-bit state through BPC shared S-box instances, BPC bytes per cycle, to trade area for latency.
- Presents the shifted, substituted state with a completion pulse.

---
 rtl/aes_subshift.sv | 173 +++++++++++++++++
 tb/tb_aes_subshift.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subshift.sv
// -----------------------------------------------------------------------------
// aes_subshift
//   Sequential SubBytes + ShiftRows stage of the AES encryption round.
//   The 128-bit state is captured on start. The stage then substitutes BPC
//   destination bytes per cycle through BPC copies of the forward S-box.
//   Each destination byte reads its ShiftRows source byte directly, so no
//   separate shift step is needed.
//
//   Ports
//     clk       in   1    rising-edge clock
//     rst       in   1    asynchronous, active-high reset
//     start     in   1    one-cycle request, honoured only in IDLE
//     state_in  in   128  AES state, byte i at [127-8i -: 8], i = 4*col + row
//     busy      out  1    high while in RUN and DONE
//     finish    out  1    one-cycle completion pulse, coincident with DONE
//     state_out out  128  SubBytes(ShiftRows(state)), same byte layout;
//                         holds its value until the next completion
//
//   Parameter
//     BPC       bytes substituted per cycle: 1, 2, 4, 8 or 16
// -----------------------------------------------------------------------------
module aes_subshift #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         finish,
  output logic [127:0] state_out
);

  localparam int         NCYC     = 16 / BPC;
  localparam int         LOG_BPC  = $clog2(BPC);
  localparam logic [3:0] LAST_CNT = 4'(NCYC - 1);

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_illegal
      $error("aes_subshift: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [3:0]   r_cnt;
  logic [7:0]   r_work   [16];
  logic [7:0]   r_result [16];
  logic [7:0]   w_result [16];
  logic [7:0]   w_in_bytes [16];
  logic [127:0] w_result_flat;
  logic         r_busy;
  logic         r_finish;
  logic [127:0] r_state_out;

  // Byte-array views of the packed input and of the next result.
  for (genvar i = 0; i < 16; i++) begin : g_bytes
    assign w_in_bytes[i]                 = state_in[127-8*i -: 8];
    assign w_result_flat[127-8*i -: 8]   = w_result[i];
  end

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Substitute this cycle's BPC destination bytes. Destination d = (row r,
  // col c) takes the work byte at (row r, col (c+r) mod 4); the 2-bit column
  // sum wraps naturally, which is the ShiftRows left rotation.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_result[i] = r_result[i];
    end
    for (int k = 0; k < BPC; k++) begin
      logic [3:0] dst;
      logic [3:0] src;
      dst = 4'((int'(r_cnt) << LOG_BPC) + k);
      src = {2'(dst[3:2] + dst[1:0]), dst[1:0]};
      w_result[dst] = sbox(r_work[src]);
    end
  end

  // FSM state, work/result registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_state_out <= 128'h0;
      for (int i = 0; i < 16; i++) begin
        r_work[i]   <= 8'h00;
        r_result[i] <= 8'h00;
      end
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work <= w_in_bytes;
            r_cnt  <= 4'd0;
          end
        end
        S_RUN: begin
          r_result <= w_result;
          r_cnt    <= r_cnt + 4'd1;
        end
        default: begin
        end
      endcase
      r_busy   <= (w_next_state != S_IDLE);
      // finish and state_out both land on the edge that enters DONE, so the
      // pulse and the new result appear in the same cycle.
      r_finish <= (r_state == S_RUN) && (w_next_state == S_DONE);
      if ((r_state == S_RUN) && (w_next_state == S_DONE)) begin
        r_state_out <= w_result_flat;
      end
    end
  end

  assign busy      = r_busy;
  assign finish    = r_finish;
  assign state_out = r_state_out;

endmodule

// File: tb/tb_aes_subshift.sv
module tb_aes_subshift;

  localparam int MAIN   = 2;  // instance index with BPC = 4
  localparam int N_MAIN = 4;  // RUN cycles of that instance

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_main = 1'b0;
  logic         start_aux  = 1'b0;
  logic [127:0] state_in   = 128'h0;
  logic [4:0]   busy_v;
  logic [4:0]   finish_v;
  logic [127:0] out_v [5];

  always #5 clk = ~clk;

  // One instance per legal BPC: instance g has BPC = 2**g.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_subshift #(.BPC(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     ((g == MAIN) ? start_main : start_aux),
      .state_in  (state_in),
      .busy      (busy_v[g]),
      .finish    (finish_v[g]),
      .state_out (out_v[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [127:0] exp;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           m_acc  = -100;
  int           m_free = 0;
  logic [127:0] m_out  = 128'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model (GF(2^8) derived, not tabulated) -------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_subshift(input logic [127:0] din);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = din[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = sbox_ref(m[r][(c+r)%4]);
    return res;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return v[7] ? ({v[6:0], 1'b0} ^ 8'h1b) : {v[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] x);
    logic [7:0]   a [4];
    logic [127:0] y;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-8*(4*c+r) -: 8];
      y[127-8*(4*c+0) -: 8] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
      y[127-8*(4*c+1) -: 8] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
      y[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
      y[127-8*(4*c+3) -: 8] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
    end
    return y;
  endfunction

  // ---------------- scoreboard monitor for the BPC=4 instance --------------
  always @(negedge clk) begin
    logic exp_fin;
    logic exp_busy;
    exp_fin = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      m_out   = sb[0].exp;
      exp_fin = 1'b1;
      void'(sb.pop_front());
    end
    exp_busy = !rst && (cyc >= m_acc + 1) && (cyc <= m_acc + N_MAIN + 1);
    check("finish",    {127'h0, finish_v[MAIN]}, {127'h0, exp_fin});
    check("busy",      {127'h0, busy_v[MAIN]},   {127'h0, exp_busy});
    check("state_out", out_v[MAIN], m_out);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_cycle(input logic s, input logic [127:0] d);
    start_main = s;
    state_in   = d;
    if (s && !rst && cyc >= m_free) begin
      sb.push_back('{exp: ref_subshift(d), due: cyc + N_MAIN + 1});
      m_acc  = cyc;
      m_free = cyc + N_MAIN + 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start_main = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    sb.delete();
    m_acc  = -100;
    m_free = 0;
    m_out  = 128'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    int lat [5];
    logic [127:0] aux_out [5];

    // Reset held for 3 cycles, then 20 idle cycles with no finish.
    do_reset(3);
    idle(20);

    // FIPS-197 Appendix B, round 1.
    drive_cycle(1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    idle(7);
    check("appb_out",    out_v[MAIN], 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("appb_mixcol", mixcol(out_v[MAIN]), 128'h046681e5e0cb199a48f8d37a2806264c);

    // All-zero state on every BPC instance at once; measure latencies.
    for (int g = 0; g < 5; g++) lat[g] = -1;
    start_aux = 1'b1;
    drive_cycle(1'b1, 128'h0);
    start_aux  = 1'b0;
    start_main = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        if (finish_v[g] && lat[g] < 0) begin
          lat[g]     = t;
          aux_out[g] = out_v[g];
        end
      end
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 5; g++) begin
      if (g != MAIN) begin
        check($sformatf("latency_bpc%0d", 1 << g), 128'(lat[g]), 128'((16 >> g) + 1));
        check($sformatf("zero_out_bpc%0d", 1 << g), aux_out[g], {16{8'h63}});
        check($sformatf("zero_hold_bpc%0d", 1 << g), out_v[g], {16{8'h63}});
      end
    end

    // Busy rejection: second start at cycles 2 and 5 (DONE) ignored.
    drive_cycle(1'b1, 128'h00112233445566778899aabbccddeeff);
    drive_cycle(1'b0, 128'h00112233445566778899aabbccddeeff);
    drive_cycle(1'b1, 128'hdeadbeefcafef00d0123456789abcdef);
    drive_cycle(1'b0, 128'hdeadbeefcafef00d0123456789abcdef);
    drive_cycle(1'b0, 128'hdeadbeefcafef00d0123456789abcdef);
    drive_cycle(1'b1, 128'hdeadbeefcafef00d0123456789abcdef);
    idle(4);

    // Reset two cycles into a run: abort, then a normal operation.
    drive_cycle(1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    drive_cycle(1'b0, 128'h3243f6a8885a308d313198a2e0370734);
    do_reset(1);
    drive_cycle(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    idle(7);

    // Start held high with fresh data every cycle.
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, {$urandom, $urandom, $urandom, $urandom});
    end
    idle(8);

    check("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
